simd_result_requant: RTL

Downstream stage of `simd_ai_accelerator`. It captures each `vec_mac_out` vector on the `result_valid` pulse and processes every lane:

- rounding shift-right requantization;
- optional ReLU;
- saturation to 8 bits.

The packed 8-bit vector is buffered in a small first-word-fall-through (FWFT) FIFO and presented on a valid/ready stream to the writeback/output logic. The accelerator has no backpressure, so the block drops vectors when full and flags it.

---
 rtl/simd_result_requant.sv | 104 ++++++++++
 1 files changed

// File: rtl/simd_result_requant.sv
// Requantizes accumulator vectors (rounding shift, optional ReLU, 8-bit saturation)
// into an FWFT FIFO with a valid/ready output. Macro SIMD_REQUANT_ROUND_EN selects round-half-up.
module simd_result_requant #(
  parameter int SIMD_LANES  = 4,
  parameter int ACC_WIDTH   = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [SIMD_LANES*ACC_WIDTH-1:0]  in_mac,
  input  logic [SHIFT_WIDTH-1:0]           shift_amt,
  input  logic                             relu_en,
  input  logic                             clr_flags,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIMD_LANES*OUT_WIDTH-1:0]  out_data,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             overflow,
  output logic [SIMD_LANES-1:0]            sat_lanes
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int VEC_W = SIMD_LANES * OUT_WIDTH;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

  logic [SHIFT_WIDTH-1:0]  sh;
  logic signed [ACC_WIDTH:0] v;
  logic [VEC_W-1:0]        rq_data;
  logic [SIMD_LANES-1:0]   rq_sat;

  logic                    s1_valid;
  logic [VEC_W-1:0]        s1_data;

  logic [VEC_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic                    full, pop, push, drop;

  // Intermediate is one bit wider than the accumulator so rounding never wraps.
  always_comb begin
    sh = shift_amt;
    if (32'(shift_amt) >= 32'(ACC_WIDTH)) sh = SHIFT_WIDTH'(ACC_WIDTH - 1);
    rq_data = '0;
    rq_sat  = '0;
    v       = '0;
    for (int unsigned i = 0; i < SIMD_LANES; i++) begin
      v = {in_mac[i*ACC_WIDTH + ACC_WIDTH - 1], in_mac[i*ACC_WIDTH +: ACC_WIDTH]};
`ifdef SIMD_REQUANT_ROUND_EN
      if (sh != '0) v = v + ((ACC_WIDTH+1)'(1) << (sh - SHIFT_WIDTH'(1)));
`endif
      v = v >>> sh;
      if (relu_en && v[ACC_WIDTH]) v = '0;
      if (v > SAT_MAX) begin
        v = SAT_MAX;
        rq_sat[i] = 1'b1;
      end else if (v < SAT_MIN) begin
        v = SAT_MIN;
        rq_sat[i] = 1'b1;
      end
      rq_data[i*OUT_WIDTH +: OUT_WIDTH] = v[OUT_WIDTH-1:0];
    end
  end

  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = s1_valid && (!full || pop);
  assign drop      = s1_valid && full && !pop;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      sat_lanes  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= rq_data;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      sat_lanes <= (clr_flags ? '0 : sat_lanes) | (in_valid ? rq_sat : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s1_data;
  end

endmodule
